if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage directly upstream of the decode stage. Owns the PC, runs a
//   req/ready handshake to instruction memory and drives the IF/ID pipeline register
//   (pc_4, instruction, valid) consumed by decode.
//   Applies redirects: exception/eret target beats branch/jump target, which beats
//   sequential PC+4. Honours decode stall and exception flush.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset
//   NOP_INSTR  32'h0000_0000  instruction injected into IF/ID on squash/flush (sll $0,$0,0)
// PORTS
//   clk              in   1   clock; all state updates on posedge
//   rst              in   1   reset; synchronous, active-low (rst==0 resets on posedge clk)
//   cpu_en           in   1   0 = freeze all state (PC, FSM, IF/ID, buffer); outputs hold
//   stall            in   1   decode stall: hold IF/ID, do not advance PC
//   branch_taken     in   1   decode resolved taken branch/jump/jr this cycle
//   branch_target    in   32  target for branch_taken
//   except_redirect  in   1   exception/interrupt/eret entry this cycle
//   except_target    in   32  handler or EPC target
//   except_clear     in   1   flush IF/ID to NOP (exception clear / eret clear)
//   imem_req         out  1   fetch request; imem_addr stable while req && !imem_ready
//   imem_addr        out  32  fetch address (current PC)
//   imem_ready       in   1   memory accepts request and returns imem_rdata same cycle
//   imem_rdata       in   32  fetched instruction, valid when imem_req && imem_ready
//   id_pc_4          out  32  PC+4 of instruction in IF/ID
//   id_instruction   out  32  instruction in IF/ID
//   id_valid         out  1   IF/ID holds a real instruction (0 = bubble)
//   if_pc            out  32  current PC (debug/trace)
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=S_REQ, id_instruction=NOP_INSTR, id_pc_4=0, id_valid=0,
//     buf_valid=0, imem_req=0 during the reset cycle, 1 from the first cycle after.
//   Priority per cycle: except_redirect > branch_taken > stall > sequential.
//   branch_taken is ignored while stall=1 (operands not final); except_redirect never is.
//   PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
//   FSM states:
//   S_REQ : imem_req=1, imem_addr=pc.
//     redirect && imem_ready -> data dropped, pc<=target, IF/ID<=NOP/valid0, stay S_REQ.
//     redirect && !imem_ready -> latch target in redir_pc, IF/ID<=NOP, go S_DROP.
//     ready && !stall -> IF/ID<={pc+4,imem_rdata,1}, pc<=pc+4, stay S_REQ.
//     ready && stall -> buf<={pc+4,imem_rdata}, pc<=pc+4, IF/ID holds, go S_HOLD.
//     !ready -> hold; IF/ID<=NOP/valid0 if !stall, else IF/ID holds.
//   S_HOLD: imem_req=0. !stall -> IF/ID<=buf, valid1, go S_REQ.
//     redirect -> buf discarded, pc<=target, IF/ID<=NOP, go S_REQ.
//   S_DROP: imem_req=1, imem_addr=old pc (handshake never aborted). On imem_ready
//     discard data, pc<=redir_pc, go S_REQ. A newer except_redirect overwrites redir_pc.
//     A newer branch_taken is ignored (IF/ID is already NOP, so decode cannot issue one).
//   except_clear: IF/ID<=NOP/valid0 that cycle regardless of stall or state.
//   Throughput 1 instr/cycle with imem_ready tied high; decode sees an instr 1 cycle after ready.
//   No branch delay slot: the sequential instruction fetched behind a taken branch is squashed.
//   cpu_en=0 outranks everything except reset; imem_req/imem_addr hold their values.
// CONFIGURATION
//   IF_MISALIGN_CHECK_EN defined: adds out port if_misaligned (1 bit, reset 0).
//     A redirect to a target with [1:0]!=0 is not fetched: pc<=target, IF/ID<=NOP,
//     if_misaligned=1 (sticky until except_redirect or reset); imem_req=0 while set.
//   Undefined: port absent; target[1:0] are forced to 2'b00 before loading pc.
// STRUCTURE
//   Shared header pipeline_defs.vh: NOP_INSTR, RESET_PC default, FSM state encodings
//     (S_REQ/S_HOLD/S_DROP, 2 bits), redirect-priority select encoding.
//   One sub-module: if_id_reg -- IF/ID register with hold (stall), flush (NOP/valid0)
//     and load; flush beats hold.
// TESTING
//   ready=1, no stall, 4 cycles from reset -> imem_addr 0,4,8,C; id_pc_4 4,8,C.
//   ready=1, stall high 3 cycles at addr 8 -> S_HOLD, imem_req=0; after release
//     id_pc_4=C then 10, no instr lost or repeated.
//   branch_taken target 0x40 while fetching 0x10 -> IF/ID NOP/valid0 for 1 cycle,
//     next imem_addr=0x40.
//   branch_taken + except_redirect (0x180) same cycle -> next imem_addr=0x180.
//   redirect to 0x80 while imem_ready=0 for 3 cycles -> imem_addr stays at old pc
//     until ready, data dropped, then 0x80.
//   cpu_en=0 for 5 cycles mid-stream, then rst low 1 cycle -> state frozen, then
//     pc=RESET_PC, id_valid=0; misaligned target 0x42 (MISALIGN_EN) -> if_misaligned=1.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: defaults, FSM states and
// redirect-priority selection.
package if_fetch_stage_pkg;

  localparam logic [31:0] NopInstr = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] ResetPc  = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StHold = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SelSeq    = 2'd0,
    SelStall  = 2'd1,
    SelBranch = 2'd2,
    SelExcept = 2'd3
  } redir_sel_e;

  // A branch resolved under stall has non-final operands, so stall masks it.
  function automatic redir_sel_e redir_sel(input logic except_redirect,
                                           input logic branch_taken,
                                           input logic stall);
    if (except_redirect)           return SelExcept;
    if (branch_taken && !stall)    return SelBranch;
    if (stall)                     return SelStall;
    return SelSeq;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush (NOP, invalid) beats load, which beats hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc4_o   <= 32'h0;
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (en_i) begin
      if (flush_i) begin
        instr_o <= NOP_INSTR;
        valid_o <= 1'b0;
      end else if (load_i) begin
        pc4_o   <= pc4_i;
        instr_o <= instr_i;
        valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, redirects and IF/ID drive.
// Optional IF_MISALIGN_CHECK_EN adds the sticky if_misaligned output.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ResetPc,
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        except_redirect,
  input  logic [31:0] except_target,
  input  logic        except_clear,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc_4,
  output logic [31:0] id_instruction,
  output logic        id_valid,
`ifdef IF_MISALIGN_CHECK_EN
  output logic        if_misaligned,
`endif
  output logic [31:0] if_pc
);

  fetch_state_e state_q, state_d;
  redir_sel_e   sel;
  logic [31:0]  pc_q, pc_d, redir_pc_q, redir_pc_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d, buf_instr_q, buf_instr_d;
  logic         req_q, req_d;
  logic         redirect, fire, pc_load_tgt;
  logic [31:0]  target, pc_seq;
  logic         id_flush, id_load;
  logic [31:0]  id_load_pc4, id_load_instr;
`ifdef IF_MISALIGN_CHECK_EN
  logic         mis_q, mis_d;
`endif

  assign sel      = redir_sel(except_redirect, branch_taken, stall);
  assign redirect = (sel == SelExcept) || (sel == SelBranch);
  assign target   = (sel == SelExcept) ? except_target : branch_target;
  assign pc_seq   = pc_q + 32'd4;
  assign fire     = req_q && imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    buf_pc4_d     = buf_pc4_q;
    buf_instr_d   = buf_instr_q;
    pc_load_tgt   = 1'b0;
    id_flush      = 1'b0;
    id_load       = 1'b0;
    id_load_pc4   = pc_seq;
    id_load_instr = imem_rdata;
`ifdef IF_MISALIGN_CHECK_EN
    mis_d         = mis_q && !except_redirect;
`endif
    case (state_q)
      StReq: begin
        if (redirect) begin
          id_flush = 1'b1;
          // An accepted-but-unanswered request must complete before the PC moves.
          if (req_q && !imem_ready) begin
            redir_pc_d = target;
            state_d    = StDrop;
          end else begin
            pc_d        = target;
            pc_load_tgt = 1'b1;
          end
        end else if (fire) begin
          pc_d = pc_seq;
          if (stall) begin
            buf_pc4_d   = pc_seq;
            buf_instr_d = imem_rdata;
            state_d     = StHold;
          end else begin
            id_load = 1'b1;
          end
        end else if (!stall) begin
          id_flush = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d        = target;
          pc_load_tgt = 1'b1;
          id_flush    = 1'b1;
          state_d     = StReq;
        end else if (!stall) begin
          id_load       = 1'b1;
          id_load_pc4   = buf_pc4_q;
          id_load_instr = buf_instr_q;
          state_d       = StReq;
        end
      end
      StDrop: begin
        id_flush = 1'b1;
        if (except_redirect) redir_pc_d = target;
        if (imem_ready) begin
          pc_d        = except_redirect ? target : redir_pc_q;
          pc_load_tgt = 1'b1;
          state_d     = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (pc_load_tgt) begin
`ifdef IF_MISALIGN_CHECK_EN
      if (|pc_d[1:0]) mis_d = 1'b1;
`else
      pc_d[1:0] = 2'b00;
`endif
    end

    if (except_clear) id_flush = 1'b1;

`ifdef IF_MISALIGN_CHECK_EN
    req_d = (state_d != StHold) && !mis_d;
`else
    req_d = (state_d != StHold);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      redir_pc_q  <= RESET_PC;
      buf_pc4_q   <= 32'h0;
      buf_instr_q <= NOP_INSTR;
      req_q       <= 1'b0;
    end else if (cpu_en) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_pc_q  <= redir_pc_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_instr_q <= buf_instr_d;
      req_q       <= req_d;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst)        mis_q <= 1'b0;
    else if (cpu_en) mis_q <= mis_d;
  end
  assign if_misaligned = mis_q;
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_pc     = pc_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (cpu_en),
    .flush_i (id_flush),
    .load_i  (id_load),
    .pc4_i   (id_load_pc4),
    .instr_i (id_load_instr),
    .pc4_o   (id_pc_4),
    .instr_o (id_instruction),
    .valid_o (id_valid)
  );

endmodule
